// File: rtl/lsu_mem_initiator.sv
// Load/store initiator between execute and the data-SRAM responder.
// One access in flight; formats load data and returns a single response.
module lsu_mem_initiator #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic        mem_req,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    typedef enum logic [2:0] {
        IDLE,
        ST_ISSUE,
        LD_ISSUE,
        LD_WAIT,
        RESP
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  alo_q, alo_d;
    logic [2:0]  f3_q, f3_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_wen_q, mem_wen_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wmask_q, mem_wmask_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_err_q, resp_err_d;

    logic        bad_f3;
    logic        misal;
    logic [3:0]  st_mask;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // Decode the incoming request: legality, alignment, store lanes.
    always_comb begin
        bad_f3  = 1'b0;
        misal   = 1'b0;
        st_mask = 4'b1111;
        st_data = in_wdata;
        if (in_is_store) begin
            bad_f3 = !(in_funct3 inside {3'b000, 3'b001, 3'b010});
        end else begin
            bad_f3 = !(in_funct3 inside
                {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end
        misal = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
        case (in_funct3[1:0])
            2'b00: begin
                st_mask = 4'b0001 << in_addr[1:0];
                st_data = {4{in_wdata[7:0]}};
            end
            2'b01: begin
                st_mask = in_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{in_wdata[15:0]}};
            end
            default: begin
                st_mask = 4'b1111;
                st_data = in_wdata;
            end
        endcase
    end

    // Pick the addressed lane out of the read word and extend it.
    always_comb begin
        ld_byte = mem_rdata[7:0];
        ld_half = alo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_data = mem_rdata;
        case (alo_q)
            2'b00:   ld_byte = mem_rdata[7:0];
            2'b01:   ld_byte = mem_rdata[15:8];
            2'b10:   ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        case (f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alo_d        = alo_q;
        f3_d         = f3_q;
        mem_req_d    = 1'b0;
        mem_wen_d    = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wmask_d  = 4'b0000;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    alo_d = in_addr[1:0];
                    f3_d  = in_funct3;
                    if (bad_f3 || misal) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_data_d  = 32'd0;
                        resp_err_d   = 1'b1;
                    end else if (in_is_store) begin
                        state_d     = ST_ISSUE;
                        mem_req_d   = 1'b1;
                        mem_wen_d   = 1'b1;
                        mem_addr_d  = {in_addr[31:2], 2'b00};
                        mem_wdata_d = st_data;
                        mem_wmask_d = st_mask;
                    end else begin
                        state_d    = LD_ISSUE;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {in_addr[31:2], 2'b00};
                    end
                end
            end
            ST_ISSUE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_data_d  = 32'd0;
                resp_err_d   = 1'b0;
            end
            LD_ISSUE: begin
                state_d = LD_WAIT;
                cnt_d   = 8'd0;
            end
            LD_WAIT: begin
                if (mem_rvalid) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_data_d  = ld_data;
                    resp_err_d   = 1'b0;
                end else if (cnt_q == TO_LAST) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_data_d  = 32'd0;
                    resp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_data_d  = 32'd0;
                    resp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared by asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            alo_q        <= 2'b00;
            f3_q         <= 3'b000;
            mem_req_q    <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            mem_wmask_q  <= 4'b0000;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alo_q        <= alo_d;
            f3_q         <= f3_d;
            mem_req_q    <= mem_req_d;
            mem_wen_q    <= mem_wen_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wmask_q  <= mem_wmask_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign mem_req    = mem_req_q;
    assign mem_wen    = mem_wen_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wmask  = mem_wmask_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Scoreboard bench for lsu_mem_initiator with a two-edge read responder.
// Latency is counted in clock edges from the accept edge to resp_valid.
module tb_lsu_mem_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_is_store = 1'b0;
    logic [2:0]  in_funct3 = 3'b000;
    logic [31:0] in_addr = 32'd0;
    logic [31:0] in_wdata = 32'd0;
    logic        mem_req;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_data;
    logic        resp_err;

    lsu_mem_initiator #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_store(in_is_store), .in_funct3(in_funct3),
        .in_addr(in_addr), .in_wdata(in_wdata),
        .mem_req(mem_req), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder: rvalid two edges after it samples a read request.
    logic        rsp_en = 1'b1;
    logic        stray = 1'b0;
    logic [31:0] rsp_word = 32'd0;
    logic        p1 = 1'b0;
    logic        rv_q = 1'b0;
    always @(posedge clk) begin
        p1   <= mem_req && !mem_wen && rsp_en;
        rv_q <= p1;
    end
    assign mem_rvalid = rv_q | stray;
    assign mem_rdata  = stray ? 32'hFFFF_FFFF : rsp_word;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mexp_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          acc;
    } rexp_t;

    mexp_t mq[$];
    rexp_t rq[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    // Monitor: pops an expectation for every memory request and response.
    logic mreq_prev = 1'b0;
    logic rv_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            mreq_prev = 1'b0;
            rv_prev   = 1'b0;
        end else begin
            if (mem_req) begin
                chk("mem_req_one_cycle", {31'd0, mreq_prev}, 32'd0);
                if (mq.size() == 0) begin
                    chk("mem_req_unexpected", 32'd1, 32'd0);
                end else begin
                    mexp_t m;
                    m = mq.pop_front();
                    chk("mem_wen", {31'd0, mem_wen}, {31'd0, m.wen});
                    chk("mem_addr", mem_addr, m.addr);
                    chk("mem_wmask", {28'd0, mem_wmask}, {28'd0, m.wmask});
                    if (m.wen) chk("mem_wdata", mem_wdata, m.wdata);
                end
            end
            if (resp_valid && !rv_prev) begin
                if (rq.size() == 0) begin
                    chk("resp_unexpected", 32'd1, 32'd0);
                end else begin
                    rexp_t r;
                    r = rq.pop_front();
                    chk("resp_data", resp_data, r.data);
                    chk("resp_err", {31'd0, resp_err}, {31'd0, r.err});
                    chk("resp_latency", 32'(cyc - r.acc), 32'(r.lat));
                end
            end
            mreq_prev = mem_req;
            rv_prev   = resp_valid;
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    endtask

    // Issue one request; pm/pr select whether mem and response are expected.
    task automatic do_req(input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rw, input bit pm,
                          input logic [3:0] emask, input logic [31:0] ewd,
                          input bit pr, input logic [31:0] ed,
                          input logic ee, input int el);
        mexp_t m;
        rexp_t r;
        wait_ready();
        in_valid    = 1'b1;
        in_is_store = st;
        in_funct3   = f3;
        in_addr     = a;
        in_wdata    = wd;
        rsp_word    = rw;
        if (pm) begin
            m.wen   = st;
            m.addr  = {a[31:2], 2'b00};
            m.wdata = ewd;
            m.wmask = emask;
            mq.push_back(m);
        end
        if (pr) begin
            r.data = ed;
            r.err  = ee;
            r.lat  = el;
            r.acc  = cyc + 1;
            rq.push_back(r);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid    = 1'b0;
        in_is_store = !st;
        in_funct3   = 3'b111;
        in_addr     = 32'h5555_5555;
        in_wdata    = 32'hFFFF_FFFF;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_mem_req"}, {31'd0, mem_req}, 32'd0);
        chk({nm, "_mem_wen"}, {31'd0, mem_wen}, 32'd0);
        chk({nm, "_mem_addr"}, mem_addr, 32'd0);
        chk({nm, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({nm, "_mem_wmask"}, {28'd0, mem_wmask}, 32'd0);
        chk({nm, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({nm, "_resp_data"}, resp_data, 32'd0);
        chk({nm, "_resp_err"}, {31'd0, resp_err}, 32'd0);
    endtask

    initial begin
        int n;
        @(negedge clk);
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // stores
        do_req(1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 0,
               1, 4'b1111, 32'hDEAD_BEEF, 1, 32'd0, 0, 1);
        do_req(1, 3'b000, 32'h8000_0003, 32'h0000_00A5, 0,
               1, 4'b1000, 32'hA5A5_A5A5, 1, 32'd0, 0, 1);
        do_req(1, 3'b001, 32'h8000_0002, 32'h0000_1234, 0,
               1, 4'b1100, 32'h1234_1234, 1, 32'd0, 0, 1);
        do_req(1, 3'b001, 32'h8000_0000, 32'hFFFF_5A3C, 0,
               1, 4'b0011, 32'h5A3C_5A3C, 1, 32'd0, 0, 1);

        // loads
        do_req(0, 3'b000, 32'h8000_0002, 0, 32'h12F4_5678,
               1, 4'b0000, 0, 1, 32'hFFFF_FFF4, 0, 3);
        do_req(0, 3'b100, 32'h8000_0002, 0, 32'h12F4_5678,
               1, 4'b0000, 0, 1, 32'h0000_00F4, 0, 3);
        do_req(0, 3'b001, 32'h8000_0002, 0, 32'h12F4_5678,
               1, 4'b0000, 0, 1, 32'h0000_12F4, 0, 3);
        do_req(0, 3'b101, 32'h8000_0000, 0, 32'h12F4_5678,
               1, 4'b0000, 0, 1, 32'h0000_5678, 0, 3);
        do_req(0, 3'b001, 32'h8000_0000, 0, 32'h0000_8001,
               1, 4'b0000, 0, 1, 32'hFFFF_8001, 0, 3);
        do_req(0, 3'b010, 32'h8000_0004, 0, 32'h89AB_CDEF,
               1, 4'b0000, 0, 1, 32'h89AB_CDEF, 0, 3);
        do_req(0, 3'b000, 32'h8000_0007, 0, 32'h80AB_CDEF,
               1, 4'b0000, 0, 1, 32'hFFFF_FF80, 0, 3);

        // errors: no memory access, response on the accept edge
        do_req(0, 3'b010, 32'h8000_0001, 0, 0,
               0, 4'b0000, 0, 1, 32'd0, 1, 0);
        do_req(0, 3'b011, 32'h8000_0000, 0, 0,
               0, 4'b0000, 0, 1, 32'd0, 1, 0);
        do_req(1, 3'b100, 32'h8000_0000, 32'h1, 0,
               0, 4'b0000, 0, 1, 32'd0, 1, 0);
        do_req(1, 3'b001, 32'h8000_0001, 32'h1, 0,
               0, 4'b0000, 0, 1, 32'd0, 1, 0);
        do_req(0, 3'b101, 32'h8000_0003, 0, 0,
               0, 4'b0000, 0, 1, 32'd0, 1, 0);

        // timeout: 16 wait cycles, then a stray rvalid while idle
        rsp_en = 1'b0;
        do_req(0, 3'b010, 32'h8000_0010, 0, 32'h1357_9BDF,
               1, 4'b0000, 0, 1, 32'd0, 1, 17);
        wait_ready();
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        chk("stray_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("stray_resp_data", resp_data, 32'd0);
        chk("stray_mem_req", {31'd0, mem_req}, 32'd0);
        chk("stray_in_ready", {31'd0, in_ready}, 32'd1);
        rsp_en = 1'b1;

        // backpressure: response held while resp_ready is low
        resp_ready = 1'b0;
        do_req(0, 3'b010, 32'h8000_0008, 0, 32'hCAFE_BABE,
               1, 4'b0000, 0, 1, 32'hCAFE_BABE, 0, 3);
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_data", resp_data, 32'hCAFE_BABE);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("hold_release_valid", {31'd0, resp_valid}, 32'd0);

        // reset during LD_WAIT; the in-flight rvalid must be dropped
        do_req(0, 3'b010, 32'h8000_0020, 0, 32'h1111_1111,
               1, 4'b0000, 0, 0, 32'd0, 0, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 chk_all_zero("midrst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_rvalid_live", {31'd0, mem_rvalid}, 32'd1);
        @(negedge clk);
        chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);

        // recovery after reset
        do_req(0, 3'b010, 32'h8000_0000, 0, 32'h0BAD_F00D,
               1, 4'b0000, 0, 1, 32'h0BAD_F00D, 0, 3);
        wait_ready();
        repeat (3) @(negedge clk);
        chk("mq_drained", 32'(mq.size()), 32'd0);
        chk("rq_drained", 32'(rq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
